// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing diff = a - b - bin, LSB first,
// one bit per clock over WIDTH cycles, with a start/busy/done handshake.
//
// Handshake: start is sampled only while idle (busy=0); an accepted start
// latches a/b/bin and raises busy from that edge. done is a one-cycle pulse
// in the cycle after the last bit is processed, with diff/bout valid and
// held until the next completion. start while busy is ignored; start during
// the done cycle is accepted (the FSM is already idle then).
//
// Optional build macro SERIAL_SUB_OVF_EN adds output ovf, the registered
// two's-complement overflow flag of the completed subtraction.
module serial_sub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             o_dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_load;
   logic             w_step;
   logic             w_last;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_br;

   logic             w_ai;
   logic             w_bi;
   logic             w_d;
   logic             w_br_next;
   logic [WIDTH-1:0] w_res_next;

   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_done;

`ifdef SERIAL_SUB_OVF_EN
   // Operand sign bits are kept aside because the operand registers shift.
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_ovf;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and control strobes: load on accepted start, step every RUN
   // cycle, last on the step that handles the MSB.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (r_cnt == LAST_BIT) begin
               w_last       = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // One-bit full subtractor on the current LSBs and the running borrow.
   always_comb begin
      w_ai       = r_a[0];
      w_bi       = r_b[0];
      w_d        = w_ai ^ w_bi ^ r_br;
      w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
      w_res_next = {w_d, r_res[WIDTH-1:1]};
   end

   // Operand shift registers, partial result, bit counter and borrow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_res <= '0;
         r_cnt <= '0;
         r_br  <= 1'b0;
      end else if (w_load) begin
         r_a   <= a;
         r_b   <= b;
         r_res <= '0;
         r_cnt <= '0;
         r_br  <= bin;
      end else if (w_step) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_next;
         r_cnt <= r_cnt + CW'(1);
         r_br  <= w_br_next;
      end
   end

   // Visible results: updated only on the completion edge so partial
   // results never appear on diff/bout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_diff <= '0;
         r_bout <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_br_next;
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Overflow: operands of different sign and result sign differs from a.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_load) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
         end
         if (w_last) begin
            r_ovf <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
         end
      end
   end

   assign ovf = r_ovf;
`endif

   assign busy        = (r_state == S_RUN);
   assign done        = r_done;
   assign diff        = r_diff;
   assign bout        = r_bout;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub (WIDTH=4): directed steps followed by random
// operations, checked against an integer-arithmetic reference model.
module tb_serial_sub;

   localparam int W = 4;
   localparam int MASK = (1 << W) - 1;

   // Clock / reset block.
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         dbg_state;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
   logic         exp_ovf_q[$];
`endif

   serial_sub #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .bin         (bin),
      .busy        (busy),
      .done        (done),
      .diff        (diff),
      .bout        (bout),
`ifdef SERIAL_SUB_OVF_EN
      .ovf         (ovf),
`endif
      .o_dbg_state (dbg_state)
   );

   int n_assert = 0;
   int n_fail = 0;

   // Scoreboard: {bout, diff} per accepted operation, in issue order.
   logic [W:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer subtraction.
   function automatic logic [W:0] model(input int av, input int bv, input int bi);
      int t;
      t = av - bv - bi;
      return {(t < 0) ? 1'b1 : 1'b0, W'(t & MASK)};
   endfunction

   function automatic logic model_ovf(input int av, input int bv, input int bi);
      int sa, sb, t;
      sa = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
      sb = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
      t = (av - bv - bi) & MASK;
      return (sa < 0) != (sb < 0) && ((t >> (W - 1)) != ((sa < 0) ? 1 : 0));
   endfunction

   // Driver: called #1 after an edge with the DUT idle; returns #1 after
   // the accepting edge.
   task automatic launch(input int av, input int bv, input int bi);
      start = 1'b1;
      a     = W'(av);
      b     = W'(bv);
      bin   = bi[0];
      exp_q.push_back(model(av, bv, bi));
`ifdef SERIAL_SUB_OVF_EN
      exp_ovf_q.push_back(model_ovf(av, bv, bi));
`endif
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done; checks latency, busy-cycle count and the result.
   task automatic wait_done(input string tag, input int exp_lat);
      int lat;
      int busy_cycles;
      logic [W:0] e;
      lat = 0;
      busy_cycles = 0;
      while (!done && lat < 3 * W) begin
         if (busy) busy_cycles++;
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, busy_cycles, exp_lat);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_diff"}, {28'd0, diff}, {28'd0, e[W-1:0]});
         check({tag, "_bout"}, {31'd0, bout}, {31'd0, e[W]});
      end
`ifdef SERIAL_SUB_OVF_EN
      if (exp_ovf_q.size() > 0) begin
         check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf_q.pop_front()});
      end
`endif
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int pulses;
      int gap;
      int av, bv, bi;

      // Reset state.
      idle_cycles(3);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_diff", {28'd0, diff}, 0);
      check("rst_bout", {31'd0, bout}, 0);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check("idle_no_done", pulses, 0);
      check("idle_busy", {31'd0, busy}, 0);

      // 9 - 3 = 6, held after completion.
      launch(9, 3, 0);
      wait_done("t_9m3", W);
      idle_cycles(1);
      check("t_9m3_done_pulse", {31'd0, done}, 0);
      idle_cycles(3);
      check("t_9m3_hold_diff", {28'd0, diff}, 6);
      check("t_9m3_hold_bout", {31'd0, bout}, 0);

      // 3 - 9 = 10 with borrow; 0 - 0 - 1 = 15 with borrow.
      launch(3, 9, 0);
      wait_done("t_3m9", W);
      check("t_3m9_const_diff", {28'd0, diff}, 10);
      idle_cycles(1);
      launch(0, 0, 1);
      check("midrun_hold_diff", {28'd0, diff}, 10);
      check("midrun_busy", {31'd0, busy}, 1);
      wait_done("t_0m0b", W);
      check("t_0m0b_const_diff", {28'd0, diff}, 15);
      check("t_0m0b_const_bout", {31'd0, bout}, 1);
      idle_cycles(1);

      // start while busy is ignored; start in the done cycle is accepted.
      launch(9, 3, 0);
      start = 1'b1;
      a     = W'(1);
      b     = W'(1);
      bin   = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("t_ignore", W - 1);
      check("t_ignore_const_diff", {28'd0, diff}, 6);
      launch(7, 2, 0);
      wait_done("t_b2b", W);
      check("t_b2b_const_diff", {28'd0, diff}, 5);
      idle_cycles(1);

      // Reset in the middle of a run: immediate clear, no done.
      launch(12, 4, 0);
      void'(exp_q.pop_back());
`ifdef SERIAL_SUB_OVF_EN
      void'(exp_ovf_q.pop_back());
`endif
      idle_cycles(2);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_done", {31'd0, done}, 0);
      check("abort_diff", {28'd0, diff}, 0);
      check("abort_bout", {31'd0, bout}, 0);
      pulses = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < W + 3; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check("abort_no_done", pulses, 0);
      launch(5, 5, 0);
      wait_done("t_5m5", W);
      check("t_5m5_const_diff", {28'd0, diff}, 0);
      check("t_5m5_const_bout", {31'd0, bout}, 0);
      idle_cycles(1);

      // Boundary operands.
      launch(0, 15, 1);
      wait_done("t_0m15b", W);
      launch(15, 0, 0);
      wait_done("t_15m0", W);
      launch(15, 15, 1);
      wait_done("t_15m15b", W);
      idle_cycles(1);

`ifdef SERIAL_SUB_OVF_EN
      launch(8, 1, 0);
      wait_done("t_ovf1", W);
      check("t_ovf1_const", {31'd0, ovf}, 1);
      check("t_ovf1_diff", {28'd0, diff}, 7);
      idle_cycles(1);
      launch(5, 2, 0);
      wait_done("t_ovf0", W);
      check("t_ovf0_const", {31'd0, ovf}, 0);
      check("t_ovf0_diff", {28'd0, diff}, 3);
      idle_cycles(1);
`endif

      // Random operations with random gaps (gap 0 = issue in the done cycle).
      for (int i = 0; i < 24; i++) begin
         av = $urandom_range(0, MASK);
         bv = $urandom_range(0, MASK);
         bi = $urandom_range(0, 1);
         launch(av, bv, bi);
         wait_done("rand", W);
         gap = $urandom_range(0, 2);
         idle_cycles(gap);
      end

      idle_cycles(2);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule
